// File: rtl/dct_channel_scheduler.sv
// Time-multiplexes one shared 8x8 DCT core across the Y, Cb and Cr channels of a block.
// Channels are issued in order Y, Cb, Cr and the three coefficient blocks are returned together.
module dct_channel_scheduler #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_DEPTH  = 8,
  parameter int PIXEL_COUNT = DATA_DEPTH * DATA_DEPTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              blk_valid,
  output logic                              blk_ready,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] y_in,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] cb_in,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] cr_in,
  output logic                              dct_in_valid,
  input  logic                              dct_in_ready,
  output logic [DATA_WIDTH*PIXEL_COUNT-1:0] dct_in_data,
  input  logic                              dct_out_valid,
  output logic                              dct_out_ready,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] dct_out_data,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [DATA_WIDTH*PIXEL_COUNT-1:0] y_dct,
  output logic [DATA_WIDTH*PIXEL_COUNT-1:0] cb_dct,
  output logic [DATA_WIDTH*PIXEL_COUNT-1:0] cr_dct,
  output logic [1:0]                        cur_ch,
  output logic                              stray_err
);

  localparam int BW = DATA_WIDTH * PIXEL_COUNT;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    iss_cnt_q, iss_cnt_d;
  logic [1:0]    ret_cnt_q, ret_cnt_d;
  logic [BW-1:0] cap_y_q, cap_y_d;
  logic [BW-1:0] cap_cb_q, cap_cb_d;
  logic [BW-1:0] cap_cr_q, cap_cr_d;
  logic [BW-1:0] in_data_q, in_data_d;
  logic [BW-1:0] y_res_q, y_res_d;
  logic [BW-1:0] cb_res_q, cb_res_d;
  logic [BW-1:0] cr_res_q, cr_res_d;
  logic          stray_q, stray_d;
  logic          accept, issue_fire, ret_fire;

  always_comb begin
    blk_ready     = (state_q == IDLE);
    dct_in_valid  = (state_q == BUSY) && (iss_cnt_q < 2'd3);
    dct_out_ready = (state_q == BUSY) && (ret_cnt_q < iss_cnt_q);
    res_valid     = (state_q == DONE);
    cur_ch        = dct_in_valid ? iss_cnt_q : 2'd3;
    accept        = blk_valid && blk_ready;
    issue_fire    = dct_in_valid && dct_in_ready;
    ret_fire      = dct_out_valid && dct_out_ready;
  end

  always_comb begin
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    ret_cnt_d = ret_cnt_q;
    cap_y_d   = cap_y_q;
    cap_cb_d  = cap_cb_q;
    cap_cr_d  = cap_cr_q;
    y_res_d   = y_res_q;
    cb_res_d  = cb_res_q;
    cr_res_d  = cr_res_q;
    stray_d   = stray_q | (dct_out_valid & ~dct_out_ready);

    case (state_q)
      IDLE: begin
        if (accept) begin
          cap_y_d   = y_in;
          cap_cb_d  = cb_in;
          cap_cr_d  = cr_in;
          iss_cnt_d = 2'd0;
          ret_cnt_d = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (issue_fire) begin
          iss_cnt_d = iss_cnt_q + 2'd1;
        end
        if (ret_fire) begin
          ret_cnt_d = ret_cnt_q + 2'd1;
          case (ret_cnt_q)
            2'd0:    y_res_d  = dct_out_data;
            2'd1:    cb_res_d = dct_out_data;
            default: cr_res_d = dct_out_data;
          endcase
          if (ret_cnt_q == 2'd2) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Issue data is looked up with the next count so it is registered and stable while stalled.
    case (iss_cnt_d)
      2'd0:    in_data_d = cap_y_d;
      2'd1:    in_data_d = cap_cb_d;
      2'd2:    in_data_d = cap_cr_d;
      default: in_data_d = in_data_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      iss_cnt_q <= 2'd0;
      ret_cnt_q <= 2'd0;
      cap_y_q   <= '0;
      cap_cb_q  <= '0;
      cap_cr_q  <= '0;
      in_data_q <= '0;
      y_res_q   <= '0;
      cb_res_q  <= '0;
      cr_res_q  <= '0;
      stray_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      cap_y_q   <= cap_y_d;
      cap_cb_q  <= cap_cb_d;
      cap_cr_q  <= cap_cr_d;
      in_data_q <= in_data_d;
      y_res_q   <= y_res_d;
      cb_res_q  <= cb_res_d;
      cr_res_q  <= cr_res_d;
      stray_q   <= stray_d;
    end
  end

  assign dct_in_data = in_data_q;
  assign y_dct       = y_res_q;
  assign cb_dct      = cb_res_q;
  assign cr_dct      = cr_res_q;
  assign stray_err   = stray_q;

endmodule

// File: tb/tb_dct_channel_scheduler.sv
// Bench for dct_channel_scheduler: a latency-5 stand-in DCT (bitwise invert) plus a block scoreboard.
module tb_dct_channel_scheduler;

  localparam int DW  = 32;
  localparam int PC  = 64;
  localparam int BW  = DW * PC;
  localparam int LAT = 5;
  localparam int NV  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          blk_valid, blk_ready;
  logic [BW-1:0] y_in, cb_in, cr_in;
  logic          dct_in_valid, dct_in_ready;
  logic [BW-1:0] dct_in_data;
  logic          dct_out_valid, dct_out_ready;
  logic [BW-1:0] dct_out_data;
  logic          res_valid, res_ready;
  logic [BW-1:0] y_dct, cb_dct, cr_dct;
  logic [1:0]    cur_ch;
  logic          stray_err;

  logic          in_ready_tb, stray_force, model_stall;
  logic          pv [LAT];
  logic [BW-1:0] pd [LAT];

  typedef struct {
    logic [31:0] y_w;
    logic [31:0] cb_w;
    logic [31:0] cr_w;
    int          stall;
    int          res_wait;
  } vec_t;

  typedef struct {
    logic [BW-1:0] y;
    logic [BW-1:0] cb;
    logic [BW-1:0] cr;
  } blk_t;

  vec_t          vecs [NV];
  blk_t          sb_q [$];
  blk_t          cur_blk, exp_blk;
  logic [BW-1:0] exp_iss;
  int            iss_seen;
  int            n_checks, n_fail;

  always #5 clk = ~clk;

  dct_channel_scheduler #(.DATA_WIDTH(DW), .DATA_DEPTH(8), .PIXEL_COUNT(PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .y_in(y_in), .cb_in(cb_in), .cr_in(cr_in),
    .dct_in_valid(dct_in_valid), .dct_in_ready(dct_in_ready), .dct_in_data(dct_in_data),
    .dct_out_valid(dct_out_valid), .dct_out_ready(dct_out_ready), .dct_out_data(dct_out_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .y_dct(y_dct), .cb_dct(cb_dct), .cr_dct(cr_dct),
    .cur_ch(cur_ch), .stray_err(stray_err)
  );

  // Stand-in DCT core: fixed LAT-cycle pipeline whose output is the inverted input block.
  assign model_stall   = pv[LAT-1] && !dct_out_ready;
  assign dct_in_ready  = in_ready_tb && !model_stall;
  assign dct_out_valid = pv[LAT-1] || stray_force;
  assign dct_out_data  = pd[LAT-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else if (!model_stall) begin
      pv[0] <= dct_in_valid && dct_in_ready;
      pd[0] <= ~dct_in_data;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  task automatic checkOutput(input string name, input bit ok,
                             input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge ahead of each rising-edge handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb_q.delete();
      iss_seen = 0;
    end else begin
      if (blk_valid && blk_ready) begin
        cur_blk.y  = y_in;
        cur_blk.cb = cb_in;
        cur_blk.cr = cr_in;
        sb_q.push_back(cur_blk);
        iss_seen = 0;
      end
      if (dct_in_valid && dct_in_ready) begin
        exp_iss = (iss_seen == 0) ? cur_blk.y : (iss_seen == 1) ? cur_blk.cb : cur_blk.cr;
        checkOutput("issue_ch", cur_ch == 2'(iss_seen), 64'(cur_ch), 64'(iss_seen));
        checkOutput("issue_data", dct_in_data == exp_iss, dct_in_data[63:0], exp_iss[63:0]);
        iss_seen++;
      end
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_underflow", 1'b0, 64'd0, 64'd1);
        end else begin
          exp_blk = sb_q.pop_front();
          checkOutput("res_y", y_dct == ~exp_blk.y, y_dct[63:0], 64'(~exp_blk.y));
          checkOutput("res_cb", cb_dct == ~exp_blk.cb, cb_dct[63:0], 64'(~exp_blk.cb));
          checkOutput("res_cr", cr_dct == ~exp_blk.cr, cr_dct[63:0], 64'(~exp_blk.cr));
          checkOutput("issue_count", iss_seen == 3, 64'(iss_seen), 64'd3);
        end
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic driveBlock(input vec_t v);
    y_in  = {PC{v.y_w}};
    cb_in = {PC{v.cb_w}};
    cr_in = {PC{v.cr_w}};
  endtask

  // Presents one block and returns just after the accepting edge.
  task automatic startBlock(input vec_t v);
    int cnt;
    driveBlock(v);
    blk_valid = 1'b1;
    cnt = 0;
    while (!blk_ready && cnt < 50) begin
      stepCycle();
      cnt++;
    end
    checkOutput("accept_timeout", blk_ready == 1'b1, 64'(blk_ready), 64'd1);
    stepCycle();
    blk_valid = 1'b0;
    checkOutput("accept_busy", !blk_ready && dct_in_valid && cur_ch == 2'd0,
                64'({blk_ready, dct_in_valid, cur_ch}), 64'b0100);
  endtask

  task automatic applyStimulus(input vec_t v, input bit exp_stray);
    int cyc;
    startBlock(v);
    cyc = 0;
    if (v.stall > 0) begin
      stepCycle();
      cyc++;
      in_ready_tb = 1'b0;
      for (int k = 0; k < v.stall; k++) begin
        stepCycle();
        cyc++;
        checkOutput("stall_ch", dct_in_valid && cur_ch == 2'd1,
                    64'({dct_in_valid, cur_ch}), 64'b101);
        checkOutput("stall_data", dct_in_data == {PC{v.cb_w}}, dct_in_data[63:0], {2{v.cb_w}});
      end
      in_ready_tb = 1'b1;
    end
    while (!res_valid && cyc < 100) begin
      stepCycle();
      cyc++;
    end
    checkOutput("latency", cyc == 8 + v.stall, 64'(cyc), 64'(8 + v.stall));
    for (int k = 0; k < v.res_wait; k++) begin
      checkOutput("hold_flags", res_valid && !blk_ready && !dct_in_valid && !dct_out_ready,
                  64'({res_valid, blk_ready, dct_in_valid, dct_out_ready}), 64'b1000);
      checkOutput("hold_y", y_dct == {PC{~v.y_w}}, y_dct[63:0], {2{~v.y_w}});
      checkOutput("hold_cr", cr_dct == {PC{~v.cr_w}}, cr_dct[63:0], {2{~v.cr_w}});
      stepCycle();
    end
    res_ready = 1'b1;
    stepCycle();
    res_ready = 1'b0;
    checkOutput("release", !res_valid && blk_ready, 64'({res_valid, blk_ready}), 64'b01);
    checkOutput("stray", stray_err == exp_stray, 64'(stray_err), 64'(exp_stray));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc;
    vec_t b1, b2;
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    blk_valid   = 1'b0;
    res_ready   = 1'b0;
    in_ready_tb = 1'b1;
    stray_force = 1'b0;
    y_in        = '0;
    cb_in       = '0;
    cr_in       = '0;

    vecs[0] = '{32'h00010000, 32'h00020000, 32'h00030000, 0, 0};
    vecs[1] = '{32'h00040000, 32'hFFFF8000, 32'h12345678, 4, 0};
    vecs[2] = '{32'hDEADBEEF, 32'h0BADF00D, 32'hCAFEBABE, 0, 10};
    vecs[3] = '{32'h55AA33CC, 32'h0F0F0F0F, 32'h80000001, 2, 3};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_flags", blk_ready && !dct_in_valid && !dct_out_ready && !res_valid,
                64'({blk_ready, dct_in_valid, dct_out_ready, res_valid}), 64'b1000);
    checkOutput("rst_cur_ch", cur_ch == 2'd3, 64'(cur_ch), 64'd3);
    checkOutput("rst_stray", stray_err == 1'b0, 64'(stray_err), 64'd0);
    checkOutput("rst_data", dct_in_data == '0 && y_dct == '0 && cr_dct == '0,
                dct_in_data[63:0] | y_dct[63:0] | cr_dct[63:0], 64'd0);
    reset_n = 1'b1;
    stepCycle();

    for (int i = 0; i < NV; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i], 1'b0);
    end

    // Stray output while idle sets the sticky flag, which survives a normal block.
    stray_force = 1'b1;
    stepCycle();
    stray_force = 1'b0;
    checkOutput("stray_set", stray_err == 1'b1, 64'(stray_err), 64'd1);
    applyStimulus(vecs[0], 1'b1);

    // Reset while one result has come back.
    startBlock(vecs[2]);
    repeat (6) stepCycle();
    checkOutput("mid_busy", dct_out_ready && !res_valid, 64'({dct_out_ready, res_valid}), 64'b10);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_flags", blk_ready && !dct_in_valid && !dct_out_ready && !res_valid,
                64'({blk_ready, dct_in_valid, dct_out_ready, res_valid}), 64'b1000);
    checkOutput("midrst_cur_ch", cur_ch == 2'd3, 64'(cur_ch), 64'd3);
    checkOutput("midrst_stray", stray_err == 1'b0, 64'(stray_err), 64'd0);
    checkOutput("midrst_y", y_dct == '0, y_dct[63:0], 64'd0);
    stepCycle();
    reset_n = 1'b1;
    stepCycle();
    applyStimulus(vecs[3], 1'b0);

    // Back-to-back blocks with valid and ready held high.
    b1 = '{32'h11111111, 32'h22222222, 32'h33333333, 0, 0};
    b2 = '{32'h44444444, 32'h55555555, 32'h66666666, 0, 0};
    driveBlock(b1);
    blk_valid = 1'b1;
    res_ready = 1'b1;
    stepCycle();
    driveBlock(b2);
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      stepCycle();
      cyc++;
    end
    checkOutput("b2b_first_latency", cyc == 8, 64'(cyc), 64'd8);
    stepCycle();
    checkOutput("b2b_idle", !res_valid && blk_ready, 64'({res_valid, blk_ready}), 64'b01);
    stepCycle();
    checkOutput("b2b_accept2", !blk_ready && dct_in_valid && cur_ch == 2'd0,
                64'({blk_ready, dct_in_valid, cur_ch}), 64'b0100);
    checkOutput("b2b_issue_y2", dct_in_data == {PC{b2.y_w}}, dct_in_data[63:0], {2{b2.y_w}});
    blk_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      stepCycle();
      cyc++;
    end
    checkOutput("b2b_second_latency", cyc == 8, 64'(cyc), 64'd8);
    stepCycle();
    res_ready = 1'b0;
    checkOutput("b2b_done", !res_valid && blk_ready, 64'({res_valid, blk_ready}), 64'b01);

    repeat (2) stepCycle();
    checkOutput("sb_empty", sb_q.size() == 0, 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
